// File: rtl/days.sv
// rtl/days.sv - day-of-month counter feeding the month counter
//
// Purpose: holds the current day of month (1..days-in-month). In run mode it
//          advances on the hour-rollover strobe and emits a one-cycle
//          done_day carry to the month counter. In setup mode the day field
//          is edited up/down by tick pulses without generating a carry.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   display      0 = run mode, 1 = display/setup mode
//   setup_day    active-low day-field edit select (setup mode only)
//   inc_dec_day  edit direction, 1 = increment, 0 = decrement
//   tick         single-cycle edit strobe
//   done_hour    single-cycle hour 23->0 rollover strobe
//   month        current month, 1..12
//   year         current year within the century, 0..99
//   day          current day of month, 1..31
//   done_day     registered one-cycle carry into the month counter

module days #(
   parameter int YEAR_W  = 7,
   parameter int LEAP_00 = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              display,
   input  logic              setup_day,
   input  logic              inc_dec_day,
   input  logic              tick,
   input  logic              done_hour,
   input  logic [5:0]        month,
   input  logic [YEAR_W-1:0] year,
   output logic [5:0]        day,
   output logic              done_day
);

   logic       leap;
   logic [5:0] max_day;

   // Within a single century only the divisible-by-4 rule applies; year 00
   // is configurable because the century it stands for may or may not leap.
   assign leap = (year[1:0] == 2'b00) && ((year != '0) || (LEAP_00 != 0));

   always_comb begin
      max_day = 6'd31;
      case (month)
         6'd4, 6'd6, 6'd9, 6'd11: max_day = 6'd30;
         6'd2:                    max_day = leap ? 6'd29 : 6'd28;
         default:                 max_day = 6'd31;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         day      <= 6'd1;
         done_day <= 1'b0;
      end else begin
         done_day <= 1'b0;
         if (day == 6'd0) begin
            day <= 6'd1;
         end else if (day > max_day) begin
            // Month or year was edited under us; pull back into range
            // without counting it as a rollover.
            day <= max_day;
         end else if (!display) begin
            if (done_hour) begin
               if (day == max_day) begin
                  day      <= 6'd1;
                  done_day <= 1'b1;
               end else begin
                  day <= day + 6'd1;
               end
            end
         end else if (!setup_day && tick) begin
            if (inc_dec_day)
               day <= (day == max_day) ? 6'd1 : day + 6'd1;
            else
               day <= (day == 6'd1) ? max_day : day - 6'd1;
         end
      end
   end

endmodule

// File: doc/days.md
Name: days

Overview:
- Day-of-month counter for the century clock.
- Sits directly upstream of the month counter: it consumes the hour-rollover strobe and produces the done_day strobe that advances the month.
- Month length follows the current month and leap-year status, so day always stays within 1..days-in-month.
- Supports manual set-up through tick-driven increment/decrement while the clock is in display/setup mode.

Parameters:
- YEAR_W, 7, width of the year input (two-digit year within the century, 0..99).
- LEAP_00, 1, when 1 year 00 is treated as a leap year; when 0 it is a common year.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- display  input  1  0 = run mode (counting); 1 = display/setup mode.
- setup_day  input  1  active-low; 0 = day field selected for editing (honoured only when display=1).
- inc_dec_day  input  1  edit direction: 1 = increment, 0 = decrement.
- tick  input  1  single-cycle edit strobe (debounced button pulse).
- done_hour  input  1  single-cycle strobe from the hour counter marking 23->0 rollover.
- month  input  6  current month, valid values 1..12.
- year  input  YEAR_W  current year within the century.
- day  output  6  current day of month, 1..31.
- done_day  output  1  single-cycle strobe to the month counter: day rolled over.

Behaviour:
- Reset (rst=0, asynchronous): day=1, done_day=0, and all internal state cleared.
- Leap rule:
  - leap = (year[1:0]==0) && (year!=0 || LEAP_00).
  - Years are limited to 0..99, so there is no further century rule.
- max_day is combinational from month and leap:
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - 29 for month 2 when leap, otherwise 28.
  - 31 for out-of-range months (0, 13..63).
- Priority on each rising edge, highest first:
  1. Illegal day: if day==0, day<=1.
  2. Clamp: else if day>max_day (e.g. after month/year edit), day<=max_day; done_day stays 0.
  3. Run mode (display=0):
     - If done_hour=1 and day==max_day: day<=1 and the done_day register is set.
     - Else if done_hour=1: day<=day+1.
     - Else: hold.
     - tick, setup_day and inc_dec_day are ignored.
  4. Setup mode (display=1, setup_day=0, tick=1):
     - inc_dec_day=1: day<=(day==max_day)?1:day+1.
     - inc_dec_day=0: day<=(day==1)?max_day:day-1.
     - done_day is never asserted in setup mode (no carry into month while editing).
  5. Otherwise: hold.
- done_day timing:
  - Registered output, high for exactly one cycle: the cycle immediately after the edge on which day wrapped to 1.
  - Cleared on the next edge unless another wrap occurs; back-to-back wraps are impossible in practice.
- Mode switch mid-count: the day value is retained; only the update rule changes. A done_hour arriving in the same cycle display rises to 1 is ignored.
- Arithmetic is 6-bit unsigned; no value outside 1..31 is ever stored after one clock of correction.
- done_day does not depend on month validity. Month 13 is treated as 31 days, and done_day is still generated at 31.

Test Plan:
- Reset then idle: assert rst=0 mid-cycle -> day=1 and done_day=0 immediately (async); release rst and hold 5 cycles -> day stays 1.
- Run-mode wrap, Jan: month=1, day preloaded to 30 via setup, display=0, two done_hour pulses -> day 31 then 1; done_day=1 for exactly the one cycle after the wrap edge.
- February leap vs common:
  - year=24, month=2, day=28, done_hour -> day=29.
  - year=23, same start -> day=1 with done_day pulse.
  - year=0: LEAP_00=1 -> 29; LEAP_00=0 -> wraps to 1.
- Setup wrap both directions: display=1, setup_day=0, month=4, day=30.
  - tick with inc=1 -> 1.
  - tick with inc=0 -> 30.
  - done_day stays 0 throughout; a tick with setup_day=1 leaves day unchanged.
- Clamp on month change: day=31, month changed 1->2 with year=23 -> day=28 on the next edge, no done_day; a subsequent change to month 3 leaves day at 28.
- Simultaneous events:
  - display=0 with tick=1 and done_hour=1 at day=15 -> day=16 (tick ignored).
  - Assert rst=0 in the cycle after a wrap -> done_day drops immediately and day=1.
